// File: rtl/led_mixer_pkg.sv
// Shared constants and helpers for the multi-channel encoder PWM dimmer.
// Optional preset feature is selected with the LED_MIXER_LOAD_EN macro.
package led_mixer_pkg;

  // Depth of the input synchroniser on every raw encoder pin
  localparam int SYNC_DEPTH = 2;

  // PWM period in clocks for a given level width: 2**bits - 1
  function automatic int unsigned period_of(input int unsigned bits);
    return (32'd1 << bits) - 32'd1;
  endfunction

  // Saturating increment: never exceeds max_v
  function automatic int unsigned sat_add(input int unsigned v,
                                          input int unsigned step,
                                          input int unsigned max_v);
    if (max_v - v < step) return max_v;
    return v + step;
  endfunction

  // Saturating decrement: never drops below zero
  function automatic int unsigned sat_sub(input int unsigned v,
                                          input int unsigned step);
    if (v < step) return 32'd0;
    return v - step;
  endfunction

endpackage

// File: rtl/led_mixer_channel.sv
// One dimmer channel: A/B synchronisers and debouncers, x1 quadrature
// decoder, saturating level register, period-aligned active level and the
// registered PWM comparator. The shared counter comes from the top.
module led_mixer_channel
  import led_mixer_pkg::*;
#(
  parameter int PWM_BITS        = 8,
  parameter int DEBOUNCE_CYCLES = 16,
  parameter int STEP            = 1
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                i_enc_a,
  input  logic                i_enc_b,
  input  logic [PWM_BITS-1:0] i_cnt,
  input  logic                i_cnt_last,
  input  logic                i_load,
  input  logic [PWM_BITS-1:0] i_load_level,
  output logic                o_pwm,
  output logic [PWM_BITS-1:0] o_level
);

  localparam int unsigned LVL_MAX = period_of(PWM_BITS);
  localparam int DB_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [DB_W-1:0] DB_LAST = DB_W'(DEBOUNCE_CYCLES - 1);

  // Index 0 carries encoder A, index 1 carries encoder B
  logic [1:0]            w_raw;
  logic [1:0]            w_synced;
  logic [SYNC_DEPTH-1:0] r_sync [2];
  logic [1:0]            r_deb;
  logic [DB_W-1:0]       r_db_cnt [2];
  logic                  r_a_prev;
  logic                  w_rise;
  logic [PWM_BITS-1:0]   r_level;
  logic [PWM_BITS-1:0]   w_level_nxt;
  logic [PWM_BITS-1:0]   r_active;
  logic                  r_pwm;

  assign w_raw       = {i_enc_b, i_enc_a};
  assign w_synced[0] = r_sync[0][SYNC_DEPTH-1];
  assign w_synced[1] = r_sync[1][SYNC_DEPTH-1];

  // Shift raw pins through the synchroniser chain
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_sync[0] <= '0;
      r_sync[1] <= '0;
    end else begin
      for (int k = 0; k < 2; k++) begin
        r_sync[k] <= {r_sync[k][SYNC_DEPTH-2:0], w_raw[k]};
      end
    end
  end

  // Accept a synced change only after it has held for DEBOUNCE_CYCLES clocks
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_deb       <= '0;
      r_db_cnt[0] <= '0;
      r_db_cnt[1] <= '0;
    end else begin
      for (int k = 0; k < 2; k++) begin
        if (w_synced[k] == r_deb[k]) begin
          r_db_cnt[k] <= '0;
        end else if (r_db_cnt[k] == DB_LAST) begin
          r_deb[k]    <= w_synced[k];
          r_db_cnt[k] <= '0;
        end else begin
          r_db_cnt[k] <= r_db_cnt[k] + DB_W'(1);
        end
      end
    end
  end

  // Detent on debounced A rising; B selects direction (0 = up, 1 = down)
  assign w_rise = r_deb[0] & ~r_a_prev;

  // Next level: saturating step on a detent, preset strobe overrides it
  always_comb begin
    w_level_nxt = r_level;
    if (w_rise) begin
      if (r_deb[1]) begin
        w_level_nxt = PWM_BITS'(sat_sub(32'(r_level), 32'(STEP)));
      end else begin
        w_level_nxt = PWM_BITS'(sat_add(32'(r_level), 32'(STEP), LVL_MAX));
      end
    end
    if (i_load) begin
      w_level_nxt = i_load_level;
    end
  end

  // Level register and A edge history
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_a_prev <= 1'b0;
      r_level  <= '0;
    end else begin
      r_a_prev <= r_deb[0];
      r_level  <= w_level_nxt;
    end
  end

  // Latch level into the comparator only at the last clock of a period
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_active <= '0;
    end else if (i_cnt_last) begin
      r_active <= r_level;
    end
  end

  // Registered PWM compare: output high while counter below active level
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_pwm <= 1'b0;
    end else begin
      r_pwm <= (i_cnt < r_active);
    end
  end

  assign o_pwm   = r_pwm;
  assign o_level = r_level;

endmodule

// File: rtl/led_mixer_multi.sv
// N-channel encoder-controlled PWM dimmer. One shared PWM counter drives
// all channels; levels reach the outputs only at period boundaries.
// Define LED_MIXER_LOAD_EN to add the load/load_level preset ports.
module led_mixer_multi
  import led_mixer_pkg::*;
#(
  parameter int NUM_CH          = 3,
  parameter int PWM_BITS        = 8,
  parameter int DEBOUNCE_CYCLES = 16,
  parameter int STEP            = 1
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic [NUM_CH-1:0]          enc_a,
  input  logic [NUM_CH-1:0]          enc_b,
  output logic [NUM_CH-1:0]          pwm_out,
  output logic [NUM_CH*PWM_BITS-1:0] level,
  output logic                       period_start
`ifdef LED_MIXER_LOAD_EN
  ,
  input  logic                       load,
  input  logic [NUM_CH*PWM_BITS-1:0] load_level
`endif
);

  localparam logic [PWM_BITS-1:0] CNT_LAST = PWM_BITS'(period_of(PWM_BITS) - 32'd1);

  logic [PWM_BITS-1:0]        r_cnt;
  logic                       r_period_start;
  logic                       w_cnt_last;
  logic                       w_load;
  logic [NUM_CH*PWM_BITS-1:0] w_load_level;

`ifdef LED_MIXER_LOAD_EN
  assign w_load       = load;
  assign w_load_level = load_level;
`else
  assign w_load       = 1'b0;
  assign w_load_level = '0;
`endif

  assign w_cnt_last = (r_cnt == CNT_LAST);

  // Shared PWM counter: 0 .. PERIOD-1 then wrap
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_cnt <= '0;
    end else if (w_cnt_last) begin
      r_cnt <= '0;
    end else begin
      r_cnt <= r_cnt + PWM_BITS'(1);
    end
  end

  // Period start flag, registered alongside the PWM outputs
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_period_start <= 1'b0;
    end else begin
      r_period_start <= (r_cnt == '0);
    end
  end

  assign period_start = r_period_start;

  for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
    led_mixer_channel #(
      .PWM_BITS       (PWM_BITS),
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
      .STEP           (STEP)
    ) u_ch (
      .clk         (clk),
      .reset       (reset),
      .i_enc_a     (enc_a[g]),
      .i_enc_b     (enc_b[g]),
      .i_cnt       (r_cnt),
      .i_cnt_last  (w_cnt_last),
      .i_load      (w_load),
      .i_load_level(w_load_level[g*PWM_BITS +: PWM_BITS]),
      .o_pwm       (pwm_out[g]),
      .o_level     (level[g*PWM_BITS +: PWM_BITS])
    );
  end

endmodule

// File: tb/tb_led_mixer_multi.sv
// Bench for led_mixer_multi: randomized encoder detents against a
// behavioural level/duty model kept in the bench.
module tb_led_mixer_multi;

  localparam int NUM_CH  = 3;
  localparam int PWM_BITS = 8;
  localparam int DB      = 16;
  localparam int STEP    = 1;
  localparam int LMAX    = (1 << PWM_BITS) - 1;
  localparam int PERIOD  = (1 << PWM_BITS) - 1;
  localparam int SETTLE  = 20;

  logic                       clk = 1'b0;
  logic                       reset;
  logic [NUM_CH-1:0]          enc_a;
  logic [NUM_CH-1:0]          enc_b;
  logic [NUM_CH-1:0]          pwm_out;
  logic [NUM_CH*PWM_BITS-1:0] level;
  logic                       period_start;
`ifdef LED_MIXER_LOAD_EN
  logic                       load;
  logic [NUM_CH*PWM_BITS-1:0] load_level;
`endif

  int n_checks = 0;
  int n_fail   = 0;
  int exp_lvl [NUM_CH];
  int duty    [NUM_CH];
  logic [NUM_CH*PWM_BITS-1:0] exp_q [$];

  led_mixer_multi #(
    .NUM_CH         (NUM_CH),
    .PWM_BITS       (PWM_BITS),
    .DEBOUNCE_CYCLES(DB),
    .STEP           (STEP)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .enc_a       (enc_a),
    .enc_b       (enc_b),
    .pwm_out     (pwm_out),
    .level       (level),
    .period_start(period_start)
`ifdef LED_MIXER_LOAD_EN
    ,
    .load        (load),
    .load_level  (load_level)
`endif
  );

  // ---------------- clock ----------------
  always #5 clk = ~clk;

  // ---------------- helpers ----------------
  task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp_v);
    n_checks++;
    if (act !== exp_v) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, act, exp_v);
    end
  endtask

  // Advance n clocks; always lands 1 time unit after a rising edge
  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  function automatic int model_step(input int v, input bit down);
    if (down) return (v - STEP < 0) ? 0 : v - STEP;
    return (v + STEP > LMAX) ? LMAX : v + STEP;
  endfunction

  function automatic logic [NUM_CH*PWM_BITS-1:0] pack_exp();
    logic [NUM_CH*PWM_BITS-1:0] p;
    p = '0;
    for (int c = 0; c < NUM_CH; c++) p[c*PWM_BITS +: PWM_BITS] = PWM_BITS'(exp_lvl[c]);
    return p;
  endfunction

  task automatic check_levels(input string tag);
    for (int c = 0; c < NUM_CH; c++)
      check($sformatf("%s_lvl%0d", tag, c), 64'(level[c*PWM_BITS +: PWM_BITS]), 64'(exp_lvl[c]));
  endtask

  // One detent on every channel in mask; down selects direction per channel
  task automatic detent(input logic [NUM_CH-1:0] mask, input logic [NUM_CH-1:0] down);
    for (int c = 0; c < NUM_CH; c++) if (mask[c]) enc_b[c] = down[c];
    tick(SETTLE);
    enc_a = enc_a | mask;
    tick(SETTLE);
    enc_a = enc_a & ~mask;
    for (int c = 0; c < NUM_CH; c++) if (mask[c]) exp_lvl[c] = model_step(exp_lvl[c], down[c]);
  endtask

  // Wait for a period start, then count high cycles per channel over one period
  task automatic measure_duty(input string tag);
    int ps;
    int waited;
    waited = 0;
    while (!period_start && waited < 2 * PERIOD) begin
      tick(1);
      waited++;
    end
    check({tag, "_ps_seen"}, 64'(period_start), 64'd1);
    for (int c = 0; c < NUM_CH; c++) duty[c] = 0;
    ps = 0;
    for (int i = 0; i < PERIOD; i++) begin
      for (int c = 0; c < NUM_CH; c++) duty[c] += int'(pwm_out[c]);
      ps += int'(period_start);
      tick(1);
    end
    check({tag, "_ps_once"}, 64'(ps), 64'd1);
    check({tag, "_ps_next"}, 64'(period_start), 64'd1);
  endtask

  task automatic check_duty(input string tag);
    measure_duty(tag);
    for (int c = 0; c < NUM_CH; c++)
      check($sformatf("%s_duty%0d", tag, c), 64'(duty[c]), 64'(exp_lvl[c]));
  endtask

  // ---------------- main sequence ----------------
  initial begin
    int old_v;
    int new_v;
    bit dn;
    reset = 1'b0;
    enc_a = '0;
    enc_b = '0;
`ifdef LED_MIXER_LOAD_EN
    load       = 1'b0;
    load_level = '0;
`endif
    for (int c = 0; c < NUM_CH; c++) exp_lvl[c] = 0;

    // Reset held with toggling pins
    for (int i = 0; i < 30; i++) begin
      enc_a = NUM_CH'($urandom_range(0, (1 << NUM_CH) - 1));
      enc_b = NUM_CH'($urandom_range(0, (1 << NUM_CH) - 1));
      tick(1);
    end
    check("rst_pwm", 64'(pwm_out), 64'd0);
    check("rst_level", 64'(level), 64'd0);
    check("rst_ps", 64'(period_start), 64'd0);
    enc_a = '0;
    enc_b = '0;
    reset = 1'b1;
    tick(1);
    check("rel_ps_first", 64'(period_start), 64'd1);
    check("rel_pwm", 64'(pwm_out), 64'd0);
    check("rel_level", 64'(level), 64'd0);
    tick(1);
    check("rel_ps_second", 64'(period_start), 64'd0);

    // Five up-detents on channel 0
    for (int i = 0; i < 5; i++) detent(3'b001, 3'b000);
    check_levels("inc");
    check_duty("inc");

    // Exact latency on channel 1: level moves on the 19th clock
    enc_b[1] = 1'b0;
    tick(SETTLE);
    enc_a[1] = 1'b1;
    tick(2 + DB);
    check("lat_before", 64'(level[1*PWM_BITS +: PWM_BITS]), 64'(exp_lvl[1]));
    tick(1);
    exp_lvl[1] = model_step(exp_lvl[1], 1'b0);
    check("lat_after", 64'(level[1*PWM_BITS +: PWM_BITS]), 64'(exp_lvl[1]));
    tick(2);
    enc_a[1] = 1'b0;
    tick(SETTLE);

    // Short A pulse on channel 2 must be rejected, a long one accepted
    enc_b[2] = 1'b0;
    tick(SETTLE);
    enc_a[2] = 1'b1;
    tick(10);
    enc_a[2] = 1'b0;
    tick(30);
    check_levels("glitch");
    enc_a[2] = 1'b1;
    tick(SETTLE);
    exp_lvl[2] = model_step(exp_lvl[2], 1'b0);
    check_levels("long");
    enc_a[2] = 1'b0;

    // Saturation high on all channels, then a dropped-not-queued down step
    for (int i = 0; i < 300; i++) detent(3'b111, 3'b000);
    check_levels("sat_hi");
    check_duty("sat_hi");
    detent(3'b001, 3'b001);
    check_levels("sat_hi_dn");
    for (int i = 0; i < 300; i++) detent(3'b111, 3'b111);
    check_levels("sat_lo");
    check_duty("sat_lo");

    // Randomized detents: bursts on random channel masks and directions
    for (int it = 0; it < 40; it++) begin
      logic [NUM_CH-1:0] m;
      logic [NUM_CH-1:0] d;
      int burst;
      m = NUM_CH'($urandom_range(1, (1 << NUM_CH) - 1));
      d = NUM_CH'($urandom_range(0, (1 << NUM_CH) - 1));
      if (it < 15) d = '0;
      burst = $urandom_range(1, 4);
      for (int b = 0; b < burst; b++) detent(m, d);
      exp_q.push_back(pack_exp());
      check($sformatf("rnd_%0d", it), 64'(level), 64'(exp_q.pop_front()));
      if (it % 10 == 9) check_duty($sformatf("rnd_duty_%0d", it));
    end

    // Period boundary: change channel 1 around cnt=100, duty moves a period later
    old_v = exp_lvl[1];
    dn = (old_v == LMAX);
    new_v = model_step(old_v, dn);
    enc_b[1] = dn;
    tick(SETTLE);
    measure_duty("bnd_pre");
    for (int c = 0; c < NUM_CH; c++) duty[c] = 0;
    for (int i = 0; i < PERIOD; i++) begin
      if (i == 81) enc_a[1] = 1'b1;
      if (i == 110) check("bnd_lvl_mid", 64'(level[1*PWM_BITS +: PWM_BITS]), 64'(new_v));
      duty[1] += int'(pwm_out[1]);
      tick(1);
    end
    check("bnd_duty_cur", 64'(duty[1]), 64'(old_v));
    exp_lvl[1] = new_v;
    check_duty("bnd_next");
    enc_a[1] = 1'b0;
    tick(SETTLE);

`ifdef LED_MIXER_LOAD_EN
    // Preset on the same clock as a channel 0 detent: preset wins
    enc_b[0] = 1'b0;
    tick(SETTLE);
    enc_a[0] = 1'b1;
    tick(2 + DB);
    load = 1'b1;
    load_level = {8'd10, 8'd20, 8'd30};
    tick(1);
    load = 1'b0;
    exp_lvl[0] = 30;
    exp_lvl[1] = 20;
    exp_lvl[2] = 10;
    check_levels("load");
    tick(3);
    check_levels("load_hold");
    check_duty("load");
    enc_a[0] = 1'b0;
    tick(SETTLE);
`endif

    // Mid-operation asynchronous reset clears everything at once
    detent(3'b111, 3'b000);
    tick(3);
    reset = 1'b0;
    #2;
    check("mid_rst_level", 64'(level), 64'd0);
    check("mid_rst_pwm", 64'(pwm_out), 64'd0);
    check("mid_rst_ps", 64'(period_start), 64'd0);
    tick(3);
    reset = 1'b1;
    for (int c = 0; c < NUM_CH; c++) exp_lvl[c] = 0;
    tick(1);
    check("mid_rel_ps", 64'(period_start), 64'd1);
    check_duty("mid_rel");

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
